// File: rtl/ahb_bridge_arbiter_if.sv
// Bus-side signals of the AHB bridge arbiter: requests and locks in, grants and ownership out.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface ahb_bridge_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 4
);
    localparam int unsigned IdxW = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [IdxW-1:0]        hmaster;
    logic                   hmastlock;
    logic                   arb_busy;

    modport slave (
        input  hbusreq, hlock, hready,
        output hgrant, hmaster, hmastlock, arb_busy
    );

    modport master (
        output hbusreq, hlock, hready,
        input  hgrant, hmaster, hmastlock, arb_busy
    );
endinterface

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter sharing the AHB-to-APB bridge slave port between NUM_MASTERS requesters.
// Grants are registered and only move on hready; a tenure counter bounds unlocked ownership.
module ahb_bridge_arbiter #(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned MAX_TENURE     = 8,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input logic                hclk,
    input logic                hreset,
    ahb_bridge_arbiter_if.slave bus
);

    localparam int unsigned IdxW = $clog2(NUM_MASTERS);

    typedef logic [IdxW-1:0]        idx_t;
    typedef logic [NUM_MASTERS-1:0] vec_t;
    typedef enum logic [1:0] {StIdle, StOwn, StLocked} state_e;

    localparam idx_t       DefIdx  = idx_t'(DEFAULT_MASTER);
    localparam idx_t       LastIdx = idx_t'(NUM_MASTERS - 1);
    localparam logic [7:0] TenLast = 8'(MAX_TENURE - 1);

    function automatic vec_t onehot(input idx_t i);
        vec_t v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First set bit searching upward from last+1 with wrap; caller checks |req.
    function automatic idx_t rr_pick(input vec_t req, input idx_t last);
        idx_t        pick;
        logic        found;
        int unsigned idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            idx = (32'(last) + i) % NUM_MASTERS;
            if (!found && req[idx[IdxW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IdxW-1:0];
            end
        end
        return pick;
    endfunction

    state_e     state_q, state_d;
    idx_t       owner_q, owner_d;
    idx_t       rr_last_q, rr_last_d;
    logic [7:0] tenure_q, tenure_d;

    vec_t hgrant_q, hgrant_d;
    idx_t hmaster_q, hmaster_d;
    logic hmastlock_q, hmastlock_d;
    logic arb_busy_q, arb_busy_d;

    vec_t others;
    idx_t pick_all;
    idx_t pick_oth;
    logic do_grant;
    idx_t grant_idx;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        tenure_d  = tenure_q;
        do_grant  = 1'b0;
        grant_idx = owner_q;

        others   = bus.hbusreq & ~onehot(owner_q);
        pick_all = rr_pick(bus.hbusreq, rr_last_q);
        pick_oth = rr_pick(others, rr_last_q);

        if (bus.hready) begin
            unique case (state_q)
                StIdle: begin
                    if (|bus.hbusreq) begin
                        do_grant  = 1'b1;
                        grant_idx = pick_all;
                    end
                end
                StOwn: begin
                    if (!bus.hbusreq[owner_q]) begin
                        if (|others) begin
                            do_grant  = 1'b1;
                            grant_idx = pick_oth;
                        end else begin
                            state_d  = StIdle;
                            tenure_d = '0;
                        end
                    end else if (bus.hlock[owner_q]) begin
                        state_d  = StLocked;
                        tenure_d = '0;
                    // >= so a saturated count from a solo tenure still hands over.
                    end else if ((tenure_q >= TenLast) && (|others)) begin
                        do_grant  = 1'b1;
                        grant_idx = pick_oth;
                    end else if (tenure_q != 8'hff) begin
                        tenure_d = tenure_q + 8'd1;
                    end
                end
                StLocked: begin
                    if (bus.hlock[owner_q]) begin
                        tenure_d = '0;
                    end else if (bus.hbusreq[owner_q]) begin
                        state_d  = StOwn;
                        tenure_d = '0;
                    end else if (|others) begin
                        do_grant  = 1'b1;
                        grant_idx = pick_oth;
                    end else begin
                        state_d  = StIdle;
                        tenure_d = '0;
                    end
                end
                default: begin
                    state_d  = StIdle;
                    tenure_d = '0;
                end
            endcase
        end

        if (do_grant) begin
            owner_d   = grant_idx;
            rr_last_d = grant_idx;
            state_d   = bus.hlock[grant_idx] ? StLocked : StOwn;
            tenure_d  = '0;
        end

        hgrant_d    = (state_d == StIdle) ? onehot(DefIdx) : onehot(owner_d);
        hmaster_d   = (state_d == StIdle) ? DefIdx : owner_d;
        hmastlock_d = (state_d == StLocked);
        arb_busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= StIdle;
            owner_q     <= DefIdx;
            rr_last_q   <= LastIdx;
            tenure_q    <= '0;
            hgrant_q    <= onehot(DefIdx);
            hmaster_q   <= DefIdx;
            hmastlock_q <= 1'b0;
            arb_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            tenure_q    <= tenure_d;
            hgrant_q    <= hgrant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            arb_busy_q  <= arb_busy_d;
        end
    end

    assign bus.hgrant    = hgrant_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;
    assign bus.arb_busy  = arb_busy_q;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed bench for ahb_bridge_arbiter: a vector table plus hand sequences for reset,
// round robin (MAX_TENURE=1 instance), tenure, stall, lock and park behaviour.
module tb_ahb_bridge_arbiter;

    logic       hclk;
    logic       hreset;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic       hready;

    int checks;
    int errors;

    ahb_bridge_arbiter_if #(.NUM_MASTERS(4)) bus0 ();
    ahb_bridge_arbiter_if #(.NUM_MASTERS(4)) bus1 ();

    assign bus0.hbusreq = hbusreq;
    assign bus0.hlock   = hlock;
    assign bus0.hready  = hready;
    assign bus1.hbusreq = hbusreq;
    assign bus1.hlock   = hlock;
    assign bus1.hready  = hready;

    ahb_bridge_arbiter #(.NUM_MASTERS(4), .MAX_TENURE(8), .DEFAULT_MASTER(0)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus0)
    );

    ahb_bridge_arbiter #(.NUM_MASTERS(4), .MAX_TENURE(1), .DEFAULT_MASTER(0)) dut_rr (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus1)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic       rdy;
        logic [3:0] grant;
        logic [1:0] master;
        logic       mlock;
        logic       busy;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hreset  = 1'b1;
        hbusreq = '0;
        hlock   = '0;
        hready  = 1'b1;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        hreset = 1'b0;
    endtask

    task automatic check_outs(input string name, input logic [3:0] g, input logic [1:0] m,
                              input logic l, input logic b);
        check({name, " hgrant"}, 32'(bus0.hgrant), 32'(g));
        check({name, " hmaster"}, 32'(bus0.hmaster), 32'(m));
        check({name, " hmastlock"}, 32'(bus0.hmastlock), 32'(l));
        check({name, " arb_busy"}, 32'(bus0.arb_busy), 32'(b));
    endtask

    logic [1:0] rr_exp[5];
    int         held;

    initial begin
        checks = 0;
        errors = 0;

        //            req      lock     rdy   grant    m     lk    busy
        vecs[0]  = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b1};
        vecs[2]  = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{4'b0110, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1};
        vecs[5]  = '{4'b0110, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[6]  = '{4'b1111, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[7]  = '{4'b1101, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1};
        vecs[8]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1};
        vecs[9]  = '{4'b0101, 4'b0001, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1};
        vecs[10] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[11] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1};
        vecs[12] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0};

        rr_exp[0] = 2'd0;
        rr_exp[1] = 2'd1;
        rr_exp[2] = 2'd2;
        rr_exp[3] = 2'd3;
        rr_exp[4] = 2'd0;

        do_reset();
        check_outs("reset", 4'b0001, 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            hbusreq = vecs[i].req;
            hlock   = vecs[i].lock;
            hready  = vecs[i].rdy;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].master, vecs[i].mlock,
                       vecs[i].busy);
        end

        // Round robin with MAX_TENURE=1: all request, grants rotate every ready edge.
        do_reset();
        hbusreq = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rr%0d hmaster", k), 32'(bus1.hmaster), 32'(rr_exp[k]));
            check($sformatf("rr%0d hgrant", k), 32'(bus1.hgrant), 32'(4'b0001 << rr_exp[k]));
        end

        // Tenure: masters 0 and 1 request; master 0 keeps the bus for 8 ready edges.
        do_reset();
        hbusreq = 4'b0011;
        step();
        check("tenure first", 32'(bus0.hgrant), 32'(4'b0001));
        held = 1;
        for (int c = 0; c < 20 && bus0.hgrant == 4'b0001; c++) begin
            step();
            if (bus0.hgrant == 4'b0001) held++;
        end
        check("tenure hold", 32'(held), 32'd8);
        check("tenure next", 32'(bus0.hgrant), 32'(4'b0010));

        // Stall at tenure expiry with owner 2; variant 0 has master 3 requesting too.
        for (int v = 0; v < 2; v++) begin
            do_reset();
            hbusreq = 4'b0100;
            step();
            check($sformatf("stall%0d own", v), 32'(bus0.hgrant), 32'(4'b0100));
            hbusreq = 4'b0110;
            repeat (7) step();
            check($sformatf("stall%0d expiry", v), 32'(bus0.hgrant), 32'(4'b0100));
            hready = 1'b0;
            if (v == 0) hbusreq = 4'b1110;
            for (int s = 0; s < 3; s++) begin
                step();
                check($sformatf("stall%0d hold%0d", v, s), 32'(bus0.hgrant), 32'(4'b0100));
            end
            hready = 1'b1;
            step();
            check($sformatf("stall%0d after", v), 32'(bus0.hgrant),
                  32'((v == 0) ? 4'b1000 : 4'b0010));
        end

        // Lock: master 1 locks with everyone requesting; holds for 20 cycles.
        do_reset();
        hbusreq = 4'b0010;
        step();
        hbusreq = 4'b1111;
        hlock   = 4'b0010;
        step();
        check_outs("lock enter", 4'b0010, 2'd1, 1'b1, 1'b1);
        held = 0;
        repeat (20) begin
            step();
            if (bus0.hgrant == 4'b0010 && bus0.hmastlock) held++;
        end
        check("lock hold", 32'(held), 32'd20);
        hbusreq = 4'b1101;
        hlock   = 4'b0000;
        step();
        check_outs("lock release", 4'b0100, 2'd2, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a locked tenure.
        hbusreq = 4'b0100;
        hlock   = 4'b0100;
        step();
        check("pre-reset lock", 32'(bus0.hmastlock), 32'd1);
        @(posedge hclk);
        #3;
        hreset = 1'b1;
        #1;
        check_outs("async reset", 4'b0001, 2'd0, 1'b0, 1'b0);
        hbusreq = '0;
        hlock   = '0;
        @(negedge hclk);
        hreset = 1'b0;

        // Park, then a single request from master 3.
        step();
        check_outs("park", 4'b0001, 2'd0, 1'b0, 1'b0);
        hbusreq = 4'b1000;
        step();
        check_outs("park grant", 4'b1000, 2'd3, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
